load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and the byte-addressed data memory.
- Handles RV32I loads and stores: LB, LH, LW, LBU, LHU, SB, SH, SW.
- For loads: sign- or zero-extends the result.
- For stores: the data memory always writes 4 bytes, so sub-word stores use a read-modify-write sequence.
- Flags misaligned accesses, out-of-range accesses and illegal funct3 before any memory write happens.

Parameters:
- MEM_BYTES, 128, size of the data memory in bytes. Legal word base is 0..MEM_BYTES-4.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request strobe; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I funct3 for the access.
- address  input  32  byte address of the access.
- store_data  input  32  store source; the low byte/half is used for SB/SH.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle completion pulse.
- error  output  1  valid only with done; 1 = access rejected.
- load_data  output  32  extended load result.
- mem_address  output  32  address to the data memory.
- mem_wdata  output  32  write word to the memory data input.
- mem_we  output  1  memory write enable.
- mem_rdata  input  32  memory read word; combinational, {addr+3, addr+2, addr+1, addr}.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - busy, done, error, mem_we = 0.
  - load_data, mem_address, mem_wdata = 0.
  - All latched request fields = 0.
  - Reset mid-operation aborts immediately. No write may occur after reset asserts.
- FSM states: IDLE, LOAD, RMW_READ, WRITE, FINISH.
- IDLE:
  - start = 1 latches is_store, funct3, address and store_data.
  - The request is then checked:
    - illegal funct3 (load 3/6/7, store 3..7) -> error;
    - halfword at an odd address -> error;
    - word with address[1:0] != 0 -> error;
    - address > MEM_BYTES-4 -> error (checked for every size).
  - Error path: go to FINISH with error = 1. No memory cycle is issued.
  - Otherwise:
    - load -> LOAD;
    - SW -> WRITE;
    - SB/SH -> RMW_READ.
- LOAD (1 cycle):
  - mem_address = latched address.
  - At the clock edge, load_data captures the extended value:
    - LB: sign-extend bits [7:0];
    - LBU: zero-extend bits [7:0];
    - LH: sign-extend bits [15:0];
    - LHU: zero-extend bits [15:0];
    - LW: full word.
  - Next state FINISH.
- RMW_READ (1 cycle):
  - mem_address = latched address.
  - Captures mem_rdata into a merge register.
  - Next state WRITE.
- WRITE (1 cycle):
  - mem_we = 1 and mem_address = latched address.
  - mem_wdata:
    - SW: store_data;
    - SB: {merge[31:8], store_data[7:0]};
    - SH: {merge[31:16], store_data[15:0]}.
  - Next state FINISH.
- FINISH (1 cycle): done = 1, error as decided in IDLE. Next state IDLE.
- Latencies, counted in cycles from the start-sampling edge to done high:
  - load: 2;
  - SW: 2;
  - SB/SH: 3;
  - error: 1.
- Outputs outside their active states:
  - mem_we is 0 in every state except WRITE.
  - mem_address holds its last value.
- load_data holds until the next successful load. Stores and errors do not change it.
- start while busy is ignored; it is not queued.
- start in the same cycle as FINISH is ignored. It is accepted on the next cycle, when the FSM is in IDLE.
- Address arithmetic is unsigned 32-bit. No wrap-around is permitted; the range check rejects it.

Test Plan:
- Reset, then memory preloaded with word 0x80FF7F01 at address 8:
  - LB 8 -> load_data 0x00000001, done 2 cycles after start;
  - LB 9 -> 0x0000007F;
  - LBU 11 -> 0x00000080;
  - LH 10 -> 0xFFFF80FF;
  - LHU 10 -> 0x000080FF;
  - LW 8 -> 0x80FF7F01.
- SW 0xDEADBEEF to address 4: one mem_we pulse with mem_wdata 0xDEADBEEF; a subsequent LW 4 returns 0xDEADBEEF.
- SB 0x000000AA to address 4, then SH 0x00001234 to address 6:
  - SB: mem_we in the 3rd cycle with mem_wdata 0xDEADBEAA;
  - SH: the memory then reads bytes 6..9 as (0x34, 0x12, ...);
  - LW 4 -> 0x1234BEAA.
- Errors, each giving done and error in cycle 1 with mem_we never asserted:
  - LH 5;
  - SW 6;
  - LW 126 (with MEM_BYTES = 128);
  - load funct3 = 3.
- start pulsed while busy during an SB is ignored; exactly one done results.
- reset driven low during WRITE: mem_we drops to 0 immediately, busy = 0. Next request behaves normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: sign/zero-extends loads and turns SB/SH into a
// read-modify-write of the 4-byte-wide data memory. Bad requests are rejected before any write.
module load_store_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] load_data,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] merge_q, merge_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] mem_address_q, mem_address_d;

    function automatic logic req_illegal(input logic st, input logic [2:0] f3,
                                         input logic [31:0] a);
        logic bad;
        bad = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (f3[1:0] == 2'd1 && a[0])
            bad = 1'b1;
        if (f3[1:0] == 2'd2 && a[1:0] != 2'd0)
            bad = 1'b1;
        // Also rejects addresses that would wrap past 2^32 when +3 is applied.
        if (a > MAX_ADDR)
            bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd4:    return {24'd0, w[7:0]};
            3'd5:    return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [31:0] old,
                                                input logic [31:0] d);
        case (f3)
            3'd0:    return {old[31:8], d[7:0]};
            3'd1:    return {old[31:16], d[15:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        funct3_d      = funct3_q;
        sdata_d       = sdata_q;
        merge_d       = merge_q;
        err_d         = err_q;
        load_data_d   = load_data_q;
        mem_address_d = mem_address_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    funct3_d = funct3;
                    sdata_d  = store_data;
                    if (req_illegal(is_store, funct3, address)) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        err_d         = 1'b0;
                        mem_address_d = address;
                        if (!is_store)
                            state_d = LOAD;
                        else if (funct3 == 3'd2)
                            state_d = WRITE;
                        else
                            state_d = RMW_READ;
                    end
                end
            end
            LOAD: begin
                load_data_d = extend_load(funct3_q, mem_rdata);
                state_d     = FINISH;
            end
            RMW_READ: begin
                merge_d = mem_rdata;
                state_d = WRITE;
            end
            WRITE:   state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            funct3_q      <= 3'd0;
            sdata_q       <= 32'd0;
            merge_q       <= 32'd0;
            err_q         <= 1'b0;
            load_data_q   <= 32'd0;
            mem_address_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            funct3_q      <= funct3_d;
            sdata_q       <= sdata_d;
            merge_q       <= merge_d;
            err_q         <= err_d;
            load_data_q   <= load_data_d;
            mem_address_q <= mem_address_d;
        end
    end

    // Decoded straight from state so an asynchronous reset drops mem_we at once.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == FINISH);
        error     = (state_q == FINISH) && err_q;
        mem_we    = (state_q == WRITE);
        mem_wdata = 32'd0;
        if (state_q == WRITE)
            mem_wdata = merge_store(funct3_q, merge_q, sdata_q);
    end

    assign load_data   = load_data_q;
    assign mem_address = mem_address_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed 128-byte memory model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        busy, done, error, mem_we;
    logic [31:0] load_data, mem_address, mem_wdata, mem_rdata;

    logic [7:0]  mem [0:127];
    logic        tb_we;
    logic [31:0] tb_addr, tb_wdata;
    int          we_count;
    logic [31:0] last_wdata;

    int n_assert = 0;
    int n_fail   = 0;

    load_store_unit #(.MEM_BYTES(128)) dut (
        .clock(clock), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .address(address), .store_data(store_data),
        .busy(busy), .done(done), .error(error), .load_data(load_data),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always_comb begin
        mem_rdata = 32'd0;
        if (mem_address <= 32'd124)
            mem_rdata = {mem[int'(mem_address[6:0]) + 3], mem[int'(mem_address[6:0]) + 2],
                         mem[int'(mem_address[6:0]) + 1], mem[int'(mem_address[6:0])]};
    end

    initial begin
        we_count   = 0;
        last_wdata = 32'd0;
    end

    always @(posedge clock) begin
        if (mem_we) begin
            if (mem_address <= 32'd124)
                for (int k = 0; k < 4; k++)
                    mem[int'(mem_address[6:0]) + k] <= mem_wdata[8*k +: 8];
            we_count   <= we_count + 1;
            last_wdata <= mem_wdata;
        end else if (tb_we) begin
            for (int k = 0; k < 4; k++)
                mem[int'(tb_addr[6:0]) + k] <= tb_wdata[8*k +: 8];
        end
    end

    function automatic logic [31:0] word_at(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with the FSM back in IDLE.
    task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic err);
        is_store   = st;
        funct3     = f3;
        address    = a;
        store_data = d;
        start      = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 10) begin
            @(posedge clock); #1;
            lat++;
        end
        err = error;
        @(posedge clock); #1;
        check("done_single_pulse", {31'd0, done}, 32'd0);
    endtask

    int          lat, we_before, dones;
    logic        err;
    logic [31:0] ld_before;

    initial begin
        reset = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        address = 32'd0; store_data = 32'd0;
        tb_we = 1'b0; tb_addr = 32'd0; tb_wdata = 32'd0;

        @(posedge clock); #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        tb_we = 1'b1;
        for (int a = 0; a < 128; a += 4) begin
            tb_addr  = 32'(a);
            tb_wdata = (a == 8) ? 32'h80FF7F01 : 32'd0;
            @(posedge clock); #1;
        end
        tb_we = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;

        // Loads
        req(1'b0, 3'd0, 32'd8, 32'd0, lat, err);
        check("lb8_data", load_data, 32'h00000001);
        check("lb8_lat", 32'(lat), 32'd2);
        check("lb8_err", {31'd0, err}, 32'd0);
        check("lb8_addr_hold", mem_address, 32'd8);
        req(1'b0, 3'd0, 32'd9, 32'd0, lat, err);
        check("lb9_data", load_data, 32'h0000007F);
        req(1'b0, 3'd4, 32'd11, 32'd0, lat, err);
        check("lbu11_data", load_data, 32'h00000080);
        req(1'b0, 3'd1, 32'd10, 32'd0, lat, err);
        check("lh10_data", load_data, 32'hFFFF80FF);
        req(1'b0, 3'd5, 32'd10, 32'd0, lat, err);
        check("lhu10_data", load_data, 32'h000080FF);
        req(1'b0, 3'd2, 32'd8, 32'd0, lat, err);
        check("lw8_data", load_data, 32'h80FF7F01);
        check("lw8_lat", 32'(lat), 32'd2);

        // Stores
        we_before = we_count;
        req(1'b1, 3'd2, 32'd4, 32'hDEADBEEF, lat, err);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_we_count", 32'(we_count - we_before), 32'd1);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);
        check("sw_load_data_held", load_data, 32'h80FF7F01);
        req(1'b0, 3'd2, 32'd4, 32'd0, lat, err);
        check("lw4_after_sw", load_data, 32'hDEADBEEF);

        we_before = we_count;
        req(1'b1, 3'd0, 32'd4, 32'h000000AA, lat, err);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_we_count", 32'(we_count - we_before), 32'd1);
        check("sb_wdata", last_wdata, 32'hDEADBEAA);
        req(1'b1, 3'd1, 32'd6, 32'h00001234, lat, err);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_wdata", last_wdata, 32'h7F011234);
        check("sh_bytes6_9", word_at(6), 32'h7F011234);
        req(1'b0, 3'd2, 32'd4, 32'd0, lat, err);
        check("lw4_after_sb_sh", load_data, 32'h1234BEAA);

        // Rejected requests
        we_before = we_count;
        ld_before = load_data;
        req(1'b0, 3'd1, 32'd5, 32'd0, lat, err);
        check("lh5_err", {31'd0, err}, 32'd1);
        check("lh5_lat", 32'(lat), 32'd1);
        req(1'b1, 3'd2, 32'd6, 32'h12345678, lat, err);
        check("sw6_err", {31'd0, err}, 32'd1);
        check("sw6_lat", 32'(lat), 32'd1);
        req(1'b0, 3'd2, 32'd126, 32'd0, lat, err);
        check("lw126_err", {31'd0, err}, 32'd1);
        req(1'b0, 3'd3, 32'd0, 32'd0, lat, err);
        check("load_f3_3_err", {31'd0, err}, 32'd1);
        req(1'b1, 3'd4, 32'd0, 32'h0, lat, err);
        check("store_f3_4_err", {31'd0, err}, 32'd1);
        req(1'b0, 3'd0, 32'd125, 32'd0, lat, err);
        check("lb125_err", {31'd0, err}, 32'd1);
        req(1'b0, 3'd0, 32'hFFFFFFFF, 32'd0, lat, err);
        check("lb_wrap_err", {31'd0, err}, 32'd1);
        check("err_no_write", 32'(we_count - we_before), 32'd0);
        check("err_load_data_held", load_data, ld_before);
        req(1'b0, 3'd0, 32'd124, 32'd0, lat, err);
        check("lb124_ok", {31'd0, err}, 32'd0);

        // start held while busy during an SB
        we_before = we_count;
        dones = 0;
        is_store = 1'b1; funct3 = 3'd0; address = 32'd0; store_data = 32'h00000055;
        start = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        start = 1'b0;
        if (done) dones++;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        check("busy_start_one_done", 32'(dones), 32'd1);
        check("busy_start_one_write", 32'(we_count - we_before), 32'd1);
        check("sb0_word", word_at(0), 32'h00000055);

        // Reset during WRITE
        we_before = we_count;
        is_store = 1'b1; funct3 = 3'd2; address = 32'd0; store_data = 32'h11111111;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("write_state_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_we", {31'd0, mem_we}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        check("rst_mid_no_write", 32'(we_count - we_before), 32'd0);
        check("rst_mid_mem0", word_at(0), 32'h00000055);
        check("rst_mid_load_data", load_data, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        req(1'b0, 3'd2, 32'd0, 32'd0, lat, err);
        check("post_rst_lw0", load_data, 32'h00000055);
        check("post_rst_lat", 32'(lat), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
